// File: rtl/vc_mux_arbiter_if.sv
// VC mux arbiter bus: FIFO-side pops, downstream push and status.
// The slave modport is the arbiter's view; master is the environment's.
interface vc_mux_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             vc0_empty;
    logic [5:0]       vc0_data;
    logic             vc1_empty;
    logic [5:0]       vc1_data;
    logic             dst_almost_full;
    logic             pop_vc0;
    logic             pop_vc1;
    logic [5:0]       data_out;
    logic             valid_out;
    logic [CNT_W-1:0] cnt_vc0;
    logic [CNT_W-1:0] cnt_vc1;
    logic             class_err;

    modport master (
        output vc0_empty, vc0_data, vc1_empty, vc1_data,
        output dst_almost_full,
        input  pop_vc0, pop_vc1, data_out, valid_out,
        input  cnt_vc0, cnt_vc1, class_err
    );

    modport slave (
        input  vc0_empty, vc0_data, vc1_empty, vc1_data,
        input  dst_almost_full,
        output pop_vc0, pop_vc1, data_out, valid_out,
        output cnt_vc0, cnt_vc1, class_err
    );
endinterface

// File: rtl/vc_mux_arbiter.sv
// Transmit-side VC0/VC1 merge: VC0 priority with a VC1 anti-starvation
// burst limit, almost-full back-pressure, counters and class check.
module vc_mux_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8
) (
    input logic              clk,
    input logic              reset,
    vc_mux_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HOLD
    } state_t;

    localparam logic [3:0]       BURST_MAX = 4'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t     state;
    logic [3:0] burst_cnt;
    logic       any_ready;
    logic       can_pop;
    logic       grant0;
    logic       grant1;

    // Grant decode; the empty and almost-full checks are same-cycle so an
    // empty FIFO is never popped and a hold blocks the pop immediately.
    always_comb begin
        any_ready = !bus.vc0_empty || !bus.vc1_empty;
        can_pop   = reset && (state == ACTIVE) && !bus.dst_almost_full;
        grant1    = can_pop && !bus.vc1_empty &&
                    (bus.vc0_empty || (burst_cnt == BURST_MAX));
        grant0    = can_pop && !bus.vc0_empty && !grant1;
    end

    assign bus.pop_vc0 = grant0;
    assign bus.pop_vc1 = grant1;

    // Control FSM plus registered output word, counters and error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            burst_cnt     <= '0;
            bus.data_out  <= '0;
            bus.valid_out <= 1'b0;
            bus.cnt_vc0   <= '0;
            bus.cnt_vc1   <= '0;
            bus.class_err <= 1'b0;
        end else begin
            bus.valid_out <= grant0 || grant1;

            if (grant0) begin
                bus.data_out <= bus.vc0_data;
                if (bus.cnt_vc0 != CNT_MAX)
                    bus.cnt_vc0 <= bus.cnt_vc0 + CNT_ONE;
                if (bus.vc0_data[5])
                    bus.class_err <= 1'b1;
            end else if (grant1) begin
                bus.data_out <= bus.vc1_data;
                if (bus.cnt_vc1 != CNT_MAX)
                    bus.cnt_vc1 <= bus.cnt_vc1 + CNT_ONE;
                if (!bus.vc1_data[5])
                    bus.class_err <= 1'b1;
            end

            // Burst only counts VC0 wins that actually made VC1 wait.
            if (bus.vc1_empty || grant1)
                burst_cnt <= '0;
            else if (grant0 && (burst_cnt < BURST_MAX))
                burst_cnt <= burst_cnt + 4'd1;

            unique case (state)
                IDLE: begin
                    if (bus.dst_almost_full)
                        state <= HOLD;
                    else if (any_ready)
                        state <= ACTIVE;
                end
                ACTIVE: begin
                    if (bus.dst_almost_full)
                        state <= HOLD;
                    else if (!any_ready)
                        state <= IDLE;
                end
                HOLD: begin
                    if (!bus.dst_almost_full)
                        state <= any_ready ? ACTIVE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vc_mux_arbiter.sv
// Directed bench for vc_mux_arbiter: FIFO queues model the VC sources,
// a second narrow-counter instance shares inputs for saturation.
module tb_vc_mux_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [5:0] outq[$];

    vc_mux_arbiter_if #(.CNT_W(8)) bus ();
    vc_mux_arbiter_if #(.CNT_W(4)) sat ();

    vc_mux_arbiter #(.MAX_BURST(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    vc_mux_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (rst_n),
        .bus   (sat)
    );

    assign sat.vc0_empty       = bus.vc0_empty;
    assign sat.vc0_data        = bus.vc0_data;
    assign sat.vc1_empty       = bus.vc1_empty;
    assign sat.vc1_data        = bus.vc1_data;
    assign sat.dst_almost_full = bus.dst_almost_full;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_heads(input logic daf);
        bus.dst_almost_full = daf;
        bus.vc0_empty = (q0.size() == 0);
        bus.vc0_data  = (q0.size() != 0) ? q0[0] : 6'h00;
        bus.vc1_empty = (q1.size() == 0);
        bus.vc1_data  = (q1.size() != 0) ? q1[0] : 6'h00;
    endtask

    task automatic step(input logic daf, output logic p0, output logic vo);
        logic [5:0] tmp;
        logic       bad;
        @(negedge clk);
        drive_heads(daf);
        #1;
        p0 = bus.pop_vc0;
        bad = (bus.pop_vc0 && q0.size() == 0) ||
              (bus.pop_vc1 && q1.size() == 0) ||
              (bus.pop_vc0 && bus.pop_vc1) ||
              ((bus.pop_vc0 || bus.pop_vc1) && (daf || !rst_n));
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL pop_legal p0=%b p1=%b daf=%b n0=%0d n1=%0d",
                     bus.pop_vc0, bus.pop_vc1, daf, q0.size(), q1.size());
        end
        if (bus.pop_vc0) tmp = q0.pop_front();
        if (bus.pop_vc1) tmp = q1.pop_front();
        @(posedge clk);
        #1;
        vo = bus.valid_out;
        if (bus.valid_out) outq.push_back(bus.data_out);
    endtask

    task automatic run_until(input int n, input int budget, input string name);
        logic p0, vo;
        int   k;
        k = 0;
        while (outq.size() < n && k < budget) begin
            step(1'b0, p0, vo);
            k++;
        end
        checks++;
        if (outq.size() < n) begin
            failures++;
            $display("FAIL %s_timeout got=%0d words required=%0d", name, outq.size(), n);
        end
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        outq.delete();
        @(negedge clk);
        rst_n = 1'b0;
        drive_heads(1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic p0, vo;
        do_reset();
        #1;
        checks++;
        if ({bus.valid_out, bus.data_out, bus.cnt_vc0, bus.cnt_vc1, bus.class_err} !== '0) begin
            failures++;
            $display("FAIL reset_state v=%b d=%h c0=%0d c1=%0d e=%b required all zero",
                     bus.valid_out, bus.data_out, bus.cnt_vc0, bus.cnt_vc1, bus.class_err);
        end
        q0 = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06};
        q1 = '{6'h21};
        repeat (3) step(1'b0, p0, vo);
        checks++;
        if (outq.size() != 2 || bus.cnt_vc0 !== 8'd2) begin
            failures++;
            $display("FAIL reset_prefix words=%0d cnt0=%0d required 2/2", outq.size(), bus.cnt_vc0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        drive_heads(1'b0);
        #1;
        checks++;
        if ({bus.valid_out, bus.data_out, bus.cnt_vc0, bus.cnt_vc1} !== '0) begin
            failures++;
            $display("FAIL reset_mid v=%b d=%h c0=%0d c1=%0d required zero",
                     bus.valid_out, bus.data_out, bus.cnt_vc0, bus.cnt_vc1);
        end
        checks++;
        if ({bus.pop_vc0, bus.pop_vc1} !== 2'b00) begin
            failures++;
            $display("FAIL reset_pop pops=%b required 00", {bus.pop_vc0, bus.pop_vc1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        outq.delete();
        run_until(1, 10, "reset_resume");
        checks++;
        if (outq.size() < 1 || outq[0] !== 6'h03) begin
            failures++;
            $display("FAIL reset_resume got=%h required=03", outq.size() ? outq[0] : 6'h3f);
        end
    endtask

    task automatic test_vc0_only();
        logic [7:0] pv, vv;
        logic p0, vo;
        logic [5:0] exp0[5];
        exp0 = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
        do_reset();
        q0 = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, p0, vo);
            pv[i] = p0;
            vv[i] = vo;
        end
        checks++;
        if (pv !== 8'b0011_1110) begin
            failures++;
            $display("FAIL vc0_pops got=%b required=00111110", pv);
        end
        checks++;
        if (vv !== 8'b0011_1110) begin
            failures++;
            $display("FAIL vc0_latency valid=%b required=00111110", vv);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (outq.size() <= i || outq[i] !== exp0[i]) begin
                failures++;
                $display("FAIL vc0_word%0d got=%h required=%h", i,
                         (outq.size() > i) ? outq[i] : 6'h3f, exp0[i]);
            end
        end
        checks++;
        if (bus.cnt_vc0 !== 8'd5 || bus.cnt_vc1 !== 8'd0 || bus.class_err !== 1'b0) begin
            failures++;
            $display("FAIL vc0_counts c0=%0d c1=%0d e=%b required 5/0/0",
                     bus.cnt_vc0, bus.cnt_vc1, bus.class_err);
        end
    endtask

    task automatic test_starvation();
        logic [5:0] exps[12];
        exps = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h21, 6'h05,
                 6'h06, 6'h07, 6'h08, 6'h22, 6'h09, 6'h0A};
        do_reset();
        q0 = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
               6'h06, 6'h07, 6'h08, 6'h09, 6'h0A};
        q1 = '{6'h21, 6'h22};
        run_until(12, 40, "starve");
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (outq.size() <= i || outq[i] !== exps[i]) begin
                failures++;
                $display("FAIL starve_word%0d got=%h required=%h", i,
                         (outq.size() > i) ? outq[i] : 6'h3f, exps[i]);
            end
        end
        checks++;
        if (bus.cnt_vc0 !== 8'd10 || bus.cnt_vc1 !== 8'd2) begin
            failures++;
            $display("FAIL starve_counts c0=%0d c1=%0d required 10/2",
                     bus.cnt_vc0, bus.cnt_vc1);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] pv, vv;
        logic p0, vo;
        do_reset();
        q0 = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08};
        for (int i = 0; i < 16; i++) begin
            step((i >= 3 && i <= 5) ? 1'b1 : 1'b0, p0, vo);
            pv[i] = p0;
            vv[i] = vo;
        end
        checks++;
        if (pv !== 16'h1F86) begin
            failures++;
            $display("FAIL bp_pops got=%h required=1f86", pv);
        end
        checks++;
        if (vv !== 16'h1F86) begin
            failures++;
            $display("FAIL bp_valid got=%h required=1f86", vv);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (outq.size() <= i || outq[i] !== 6'(i + 1)) begin
                failures++;
                $display("FAIL bp_word%0d got=%h required=%h", i,
                         (outq.size() > i) ? outq[i] : 6'h3f, 6'(i + 1));
            end
        end
        checks++;
        if (outq.size() != 8 || bus.cnt_vc0 !== 8'd8) begin
            failures++;
            $display("FAIL bp_count words=%0d cnt0=%0d required 8/8",
                     outq.size(), bus.cnt_vc0);
        end
    endtask

    task automatic test_class_err();
        logic p0, vo;
        do_reset();
        q0 = '{6'h25};
        step(1'b0, p0, vo);
        checks++;
        if (bus.class_err !== 1'b0) begin
            failures++;
            $display("FAIL cls_before got=%b required=0", bus.class_err);
        end
        step(1'b0, p0, vo);
        checks++;
        if (bus.class_err !== 1'b1 || bus.valid_out !== 1'b1 || bus.data_out !== 6'h25) begin
            failures++;
            $display("FAIL cls_set e=%b v=%b d=%h required 1/1/25",
                     bus.class_err, bus.valid_out, bus.data_out);
        end
        repeat (3) step(1'b0, p0, vo);
        checks++;
        if (bus.class_err !== 1'b1) begin
            failures++;
            $display("FAIL cls_sticky got=%b required=1", bus.class_err);
        end
        do_reset();
        #1;
        checks++;
        if (bus.class_err !== 1'b0) begin
            failures++;
            $display("FAIL cls_reset got=%b required=0", bus.class_err);
        end
        q1 = '{6'h05};
        run_until(1, 10, "cls_vc1");
        checks++;
        if (bus.class_err !== 1'b1 || outq.size() < 1 || outq[0] !== 6'h05) begin
            failures++;
            $display("FAIL cls_vc1 e=%b d=%h required 1/05", bus.class_err,
                     outq.size() ? outq[0] : 6'h3f);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) q1.push_back(6'(6'h20 + i));
        run_until(20, 50, "sat");
        checks++;
        if (sat.cnt_vc1 !== 4'd15 || sat.cnt_vc0 !== 4'd0) begin
            failures++;
            $display("FAIL sat_narrow c1=%0d c0=%0d required 15/0",
                     sat.cnt_vc1, sat.cnt_vc0);
        end
        checks++;
        if (bus.cnt_vc1 !== 8'd20 || bus.class_err !== 1'b0) begin
            failures++;
            $display("FAIL sat_wide c1=%0d e=%b required 20/0",
                     bus.cnt_vc1, bus.class_err);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.vc0_empty       = 1'b1;
        bus.vc0_data        = 6'h00;
        bus.vc1_empty       = 1'b1;
        bus.vc1_data        = 6'h00;
        bus.dst_almost_full = 1'b0;
        test_reset();
        test_vc0_only();
        test_starvation();
        test_backpressure();
        test_class_err();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vc_mux_arbiter.md
# vc_mux_arbiter

Merges the two virtual-channel streams (VC0, VC1) into a single 6-bit word stream on the transmit side of the transmission layer. It is the mirror of the receive-side VC demultiplexer. It pops first-word-fall-through VC FIFOs under a VC0-priority policy with an anti-starvation burst limit, honours downstream almost-full back-pressure, and keeps per-VC forwarded-word counters plus a sticky class-error flag.

## Interface
- MAX_BURST, 4: max consecutive VC0 grants while VC1 is non-empty before VC1 is forced a grant (range 1..15)
- CNT_W, 8: width of the per-VC forwarded-word counters
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- vc0_empty  in  1  VC0 FIFO empty
- vc0_data  in  6  VC0 FIFO head word (FWFT, valid while !vc0_empty)
- vc1_empty  in  1  VC1 FIFO empty
- vc1_data  in  6  VC1 FIFO head word (FWFT)
- dst_almost_full  in  1  downstream FIFO almost-full
- pop_vc0  out  1  consume VC0 head this cycle (combinational)
- pop_vc1  out  1  consume VC1 head this cycle (combinational)
- data_out  out  6  merged word (registered)
- valid_out  out  1  data_out valid / push to downstream (registered)
- cnt_vc0  out  CNT_W  words forwarded from VC0, saturating
- cnt_vc1  out  CNT_W  words forwarded from VC1, saturating
- class_err  out  1  sticky: a forwarded word's bit 5 disagreed with its VC

## Operation
- FSM states: IDLE, ACTIVE, HOLD.
  - IDLE: both FIFOs empty or just out of reset. Go to ACTIVE when either FIFO is non-empty and dst_almost_full=0. Go to HOLD when dst_almost_full=1.
  - ACTIVE: one pop per cycle. Go to HOLD on dst_almost_full=1. Go to IDLE when both FIFOs are empty.
  - HOLD: no pops. Return to ACTIVE (or IDLE if both empty) on the first cycle with dst_almost_full=0.
- Pops are issued only in ACTIVE, and only when dst_almost_full=0 in the same cycle. A combinational override blocks the pop in the transition cycle.
- Grant rule:
  - Only one non-empty VC: grant it.
  - Both non-empty: grant VC0 unless burst_cnt == MAX_BURST, in which case grant VC1.
- burst_cnt, 4 bits:
  - Increments on a VC0 grant while VC1 is non-empty.
  - Clears on any VC1 grant, or when VC1 is empty.
  - Never exceeds MAX_BURST.
- Exactly one of pop_vc0/pop_vc1 is high per grant; both high is illegal.
- On a grant, the selected head word is registered to data_out unchanged, and valid_out=1 on the next cycle. Otherwise valid_out=0 and data_out holds its last value.
- Counters: the granted VC's counter increments by 1 per grant and saturates at 2^CNT_W-1.
- class_err is set when a VC0 word with bit5=1, or a VC1 word with bit5=0, is forwarded. The word is still forwarded. Cleared only by reset.

## Timing
- Reset (async assert, sync deassert expected externally) forces: state=IDLE, burst_cnt=0, data_out=0, valid_out=0, cnt_vc0=0, cnt_vc1=0, class_err=0. pop_vc0/pop_vc1 are 0 while reset=0.
- Reset mid-stream: outputs clear immediately. No pop is issued in the cycle reset is low. The FIFO head in flight is not consumed.
- Latency: pop in cycle N gives data_out/valid_out in cycle N+1.
- Throughput: 1 word/cycle while ACTIVE with no back-pressure.
- Back-pressure:
  - dst_almost_full high in cycle N means no pop in cycle N.
  - A word popped in cycle N-1 still appears with valid_out in cycle N. The downstream almost-full threshold must leave at least 1 free entry.
- Simultaneous events:
  - A FIFO going empty in the same cycle as its grant is resolved by the combinational empty check: no pop of an empty FIFO, ever.
  - dst_almost_full rising together with a burst limit: the hold wins, and burst_cnt is unchanged.
- Counter saturation: at max, further grants leave the counter at max. No wrap.

## Test plan
- Reset: drive reset=0 mid-stream with both FIFOs non-empty.
  - Required: valid_out=0, data_out=0, counters=0, and no pops in that cycle.
  - After release, forwarding resumes from the current heads.
- VC0 only: preload VC0 with 0x01..0x05, VC1 empty.
  - Required: pop_vc0 in 5 consecutive cycles, data_out 0x01..0x05 on valid_out one cycle later, cnt_vc0=5.
- Starvation limit: MAX_BURST=4, VC0 with 10 words, VC1 with 0x21,0x22.
  - Required output order: 4 VC0 words, 0x21, 4 VC0 words, 0x22, remaining VC0 words.
- Back-pressure: assert dst_almost_full for 3 cycles mid-stream.
  - Required: pops stop in the same cycle, at most 1 trailing valid_out, no word lost or duplicated, resume the cycle after deassert.
- Class error: push 0x25 into VC0.
  - Required: 0x25 forwarded, class_err=1 from the next cycle and held until reset.
- Saturation: CNT_W=4, forward 20 VC1 words.
  - Required: cnt_vc1=15, cnt_vc0=0.
